// File: rtl/dm_irq_pkg.sv
// dm_irq_pkg: shared injector states and byte-lane masks for the data-memory/interrupt model
package dm_irq_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, ASSERT, DONE} irq_state_t;
  localparam logic [31:0] LANE0_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE1_MASK = 32'h0000_FF00;
  localparam logic [31:0] LANE2_MASK = 32'h00FF_0000;
  localparam logic [31:0] LANE3_MASK = 32'hFF00_0000;
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return (be[0] ? LANE0_MASK : 32'h0) | (be[1] ? LANE1_MASK : 32'h0) |
           (be[2] ? LANE2_MASK : 32'h0) | (be[3] ? LANE3_MASK : 32'h0);
  endfunction
endpackage

// File: rtl/dm_irq_model_irq_injector.sv
// irq_injector: PC-triggered interrupt pulse with hold timeout and write-acknowledge
module irq_injector
  import dm_irq_pkg::*;
#(
  parameter int          HOLD_CYCLES = 8,
  parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
  parameter bit          REARM       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_en,
  input  logic [31:0] trig_pc,
  input  logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  output logic        is_ack,
  output logic        interrupt
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  irq_state_t state;
  logic [CW-1:0] cnt;
  logic ack;
  assign is_ack = (m_data_addr & ~32'd3) == ACK_ADDR;
  assign ack = |m_data_byteen && is_ack;
  // injector FSM: arm, fire on PC match, hold until timeout or ack, then rearm or park
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      interrupt <= 1'b0;
      cnt <= '0;
    end else if (!trig_en) begin
      state <= IDLE;
      interrupt <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= ARMED;
        ARMED: if (m_inst_addr == trig_pc) begin
          state <= ASSERT;
          interrupt <= 1'b1;
          cnt <= CW'(HOLD_CYCLES - 1);
        end
        ASSERT: if (cnt == '0 || ack) begin
          state <= DONE;
          interrupt <= 1'b0;
        end else cnt <= cnt - 1'b1;
        DONE: if (REARM) state <= ARMED;
      endcase
    end
  end
endmodule

// File: rtl/dm_irq_model.sv
// dm_irq_model: byte-enable data memory with range check, write counter and interrupt injector
module dm_irq_model
  import dm_irq_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          HOLD_CYCLES = 8,
  parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
  parameter bit          REARM       = 1'b0,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_wdata,
  input  logic [3:0]       m_data_byteen,
  output logic [31:0]      m_data_rdata,
  input  logic [31:0]      m_inst_addr,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  output logic             interrupt,
  output logic             oob_err,
  output logic [CNT_W-1:0] wr_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] idx;
  logic [AW-1:0] widx;
  logic in_range, is_ack, we;
  logic [31:0] mask;
  assign idx = m_data_addr[31:2];
  assign widx = idx[AW-1:0];
  assign in_range = {2'b00, idx} < DEPTH_WORDS;
  assign we = |m_data_byteen && in_range;
  assign mask = byte_mask(m_data_byteen);
  // reads return the pre-write contents; out-of-range reads as zero
  always_comb m_data_rdata = in_range ? mem[widx] : 32'h0;
  // whole array clears on reset; enabled lanes merge into the addressed word
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    else if (we) mem[widx] <= (mem[widx] & ~mask) | (m_data_wdata & mask);
  end
  // saturating committed-write count and sticky out-of-range flag; ack writes count as neither
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      oob_err <= 1'b0;
    end else begin
      if (we) wr_count <= wr_count + CNT_W'(wr_count != '1);
      if (|m_data_byteen && !in_range && !is_ack) oob_err <= 1'b1;
    end
  end
  irq_injector #(.HOLD_CYCLES(HOLD_CYCLES), .ACK_ADDR(ACK_ADDR), .REARM(REARM)) u_inj (
    .clk(clk),
    .reset(reset),
    .trig_en(trig_en),
    .trig_pc(trig_pc),
    .m_inst_addr(m_inst_addr),
    .m_data_addr(m_data_addr),
    .m_data_byteen(m_data_byteen),
    .is_ack(is_ack),
    .interrupt(interrupt)
  );
endmodule

// File: tb/tb_dm_irq_model.sv
// tb_dm_irq_model: scoreboard bench for memory, range flag, write count and interrupt pulses
module tb_dm_irq_model;
  logic clk = 0, reset = 1;
  logic [31:0] m_data_addr = 0, m_data_wdata = 0, m_inst_addr = 0, trig_pc = 32'h3010;
  logic [3:0] m_data_byteen = 0;
  logic trig_en = 0;
  logic [31:0] rdata, rdata_r;
  logic irq, irq_r, oob, oob_r;
  logic [15:0] wcnt, wcnt_r;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int due; int sel; logic [31:0] exp; string tag;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  dm_irq_model #(.REARM(1'b0)) dut (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(rdata), .m_inst_addr(m_inst_addr),
    .trig_en(trig_en), .trig_pc(trig_pc), .interrupt(irq), .oob_err(oob), .wr_count(wcnt));
  dm_irq_model #(.REARM(1'b1)) dut_r (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(rdata_r), .m_inst_addr(m_inst_addr),
    .trig_en(trig_en), .trig_pc(trig_pc), .interrupt(irq_r), .oob_err(oob_r), .wr_count(wcnt_r));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return rdata;
      1: return {31'b0, irq};
      2: return {31'b0, oob};
      3: return {16'b0, wcnt};
      default: return {31'b0, irq_r};
    endcase
  endfunction

  task automatic expect_at(input int d, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.due = cyc + d; e.sel = sel; e.exp = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].due <= cyc) begin
        check(sbq[i].tag, observe(sbq[i].sel), sbq[i].exp);
        sbq.delete(i);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be;
    tick();
    m_data_byteen = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic arm();
    trig_en = 0;
    tick();
    trig_en = 1;
    tick();
    tick();
  endtask

  task automatic expect_pulse(input int sel, input int len, input string tag);
    for (int k = 1; k <= len; k++) expect_at(k, sel, 1, tag);
    expect_at(len + 1, sel, 0, {tag, "_end"});
  endtask

  initial begin
    do_reset();
    tick();
    m_data_addr = 32'h10;
    expect_at(0, 1, 0, "rst_irq"); expect_at(0, 2, 0, "rst_oob");
    expect_at(0, 3, 0, "rst_wcnt"); expect_at(0, 0, 0, "rst_mem");
    settle();
    wr(32'h10, 32'h1122_3344, 4'b1111);
    wr(32'h10, 32'hAABB_CCDD, 4'b0101);
    m_data_addr = 32'h10;
    expect_at(0, 0, 32'h11BB_33DD, "merge"); expect_at(0, 3, 2, "wcnt2"); expect_at(0, 2, 0, "oob_clean");
    settle();
    wr(32'h13, 32'h0000_00EE, 4'b0001);
    m_data_addr = 32'h10;
    expect_at(0, 0, 32'h11BB_33EE, "addr_lsb_ignored"); expect_at(0, 3, 3, "wcnt3");
    settle();
    wr(32'h4000, 32'hDEAD_BEEF, 4'b1111);
    m_data_addr = 32'h4000;
    expect_at(0, 0, 0, "oob_read"); expect_at(0, 2, 1, "oob_set"); expect_at(0, 3, 3, "oob_wcnt");
    settle();
    m_data_addr = 32'h0;
    expect_at(0, 0, 0, "oob_no_alias");
    expect_at(3, 2, 1, "oob_sticky");
    settle();
    tick(); tick(); tick();
    do_reset();
    expect_at(0, 2, 0, "oob_cleared");
    settle();
    arm();
    m_inst_addr = 32'h3010;
    expect_pulse(1, 8, "pulse8"); expect_pulse(4, 8, "pulse8_r");
    tick();
    m_inst_addr = 0;
    for (int i = 0; i < 10; i++) tick();
    wr(32'h10, 32'hCAFE_F00D, 4'b1111);
    arm();
    m_inst_addr = 32'h3010;
    for (int k = 1; k <= 3; k++) expect_at(k, 1, 1, "ack_hi");
    for (int k = 4; k <= 6; k++) expect_at(k, 1, 0, "ack_lo");
    tick();
    m_inst_addr = 0;
    tick(); tick();
    wr(32'h7F20, 32'h1234_5678, 4'b1111);
    tick(); tick();
    m_data_addr = 32'h10;
    expect_at(0, 0, 32'hCAFE_F00D, "ack_mem"); expect_at(0, 3, 1, "ack_wcnt"); expect_at(0, 2, 0, "ack_oob");
    settle();
    wr(32'h7F20, 32'h0, 4'b1111);
    expect_at(0, 1, 0, "ack_idle"); expect_at(0, 2, 0, "ack_idle_oob"); expect_at(0, 3, 1, "ack_idle_wcnt");
    settle();
    arm();
    m_inst_addr = 32'h3010;
    expect_pulse(1, 8, "first"); expect_pulse(4, 8, "first_r");
    tick();
    m_inst_addr = 0;
    for (int i = 0; i < 19; i++) tick();
    m_inst_addr = 32'h3010;
    expect_pulse(4, 8, "second_r");
    for (int k = 1; k <= 10; k++) expect_at(k, 1, 0, "no_second");
    tick();
    m_inst_addr = 0;
    for (int i = 0; i < 10; i++) tick();
    arm();
    m_inst_addr = 32'h3010;
    for (int k = 1; k <= 3; k++) expect_at(k, 1, 1, "pre_rst");
    tick();
    m_inst_addr = 0;
    tick(); tick();
    m_data_addr = 32'h10;
    expect_at(1, 1, 0, "rst_drop"); expect_at(1, 0, 0, "rst_mem_clr"); expect_at(1, 3, 0, "rst_wcnt0");
    do_reset();
    tick();
    m_inst_addr = 32'h3010;
    expect_at(1, 1, 1, "rearmed");
    tick();
    m_inst_addr = 0;
    for (int i = 0; i < 10; i++) tick();
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
